// File: rtl/cv32e40p_pkg.sv
// Shared types for the cv32e40p buffering FIFOs.
// Only the error status is shared; the pointer and count widths stay parametrised inside each FIFO.
package cv32e40p_pkg;

  typedef struct packed {
    logic overflow;
    logic underflow;
  } fifo_err_t;

endpackage

// File: rtl/cv32e40p_fifo_wm_ptr.sv
// Wrap-aware pointer adder for a DEPTH-entry ring, DEPTH need not be a power of two.
// Computes (ptr + add_val + inc_en) folded back into 0..DEPTH-1.
module cv32e40p_fifo_wm_ptr #(
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_DEPTH = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic [ADDR_DEPTH-1:0] ptr,
  input  logic                  inc_en,
  input  logic [ADDR_DEPTH:0]   add_val,
  output logic [ADDR_DEPTH-1:0] ptr_next
);

  localparam int unsigned SW = ADDR_DEPTH + 2;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);

  logic [SW-1:0] sum;
  logic [SW-1:0] once;

  // add_val never exceeds DEPTH, so the sum stays below 2*DEPTH+1 and two folds suffice
  always_comb begin
    sum      = SW'(ptr) + SW'(add_val) + SW'(inc_en);
    once     = (sum >= DEPTH_S) ? (sum - DEPTH_S) : sum;
    ptr_next = (once >= DEPTH_S) ? ADDR_DEPTH'(once - DEPTH_S) : ADDR_DEPTH'(once);
  end

endmodule

// File: rtl/cv32e40p_fifo_wm.sv
// FIFO with programmable almost-full/almost-empty watermarks, partial flush that keeps
// the oldest entries, sticky overflow/underflow flags and optional fall-through.
module cv32e40p_fifo_wm
  import cv32e40p_pkg::*;
#(
  parameter logic        FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned ADDR_DEPTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  setback_i,
  input  logic                  flush_i,
  input  logic                  flush_keep_i,
  input  logic [ADDR_DEPTH:0]   keep_cnt_i,
  input  logic [ADDR_DEPTH:0]   afull_thr_i,
  input  logic [ADDR_DEPTH:0]   aempty_thr_i,
  input  logic                  err_clr_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic                  full_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i,
  output logic                  empty_o,
  output logic [ADDR_DEPTH:0]   cnt_o,
  output logic                  almost_full_o,
  output logic                  almost_empty_o,
  output logic                  overflow_o,
  output logic                  underflow_o
);

  localparam logic [ADDR_DEPTH:0] DEPTH_CNT = (ADDR_DEPTH + 1)'(DEPTH);
  localparam logic [ADDR_DEPTH:0] CNT_ONE   = (ADDR_DEPTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_DEPTH-1:0] rptr;
  logic [ADDR_DEPTH-1:0] wptr;
  logic [ADDR_DEPTH-1:0] rptr_next;
  logic [ADDR_DEPTH-1:0] wptr_next;
  logic [ADDR_DEPTH-1:0] wptr_keep;
  logic [ADDR_DEPTH:0]   cnt;
  logic [ADDR_DEPTH:0]   kept;
  fifo_err_t             err;
  fifo_err_t             err_next;

  logic cnt_zero;
  logic ft_hit;
  logic flushing;
  logic push_acc;
  logic pop_acc;
  logic ovf_set;
  logic unf_set;

  assign cnt_zero = (cnt == '0);
  assign ft_hit   = FALL_THROUGH && cnt_zero && push_i;
  assign flushing = setback_i | flush_i | flush_keep_i;

  assign full_o  = (cnt == DEPTH_CNT);
  assign empty_o = cnt_zero & ~ft_hit;
  assign data_o  = ft_hit ? data_i : mem[rptr];
  assign cnt_o   = cnt;

  // A fall-through push that is popped in the same cycle bypasses storage entirely
  assign push_acc = push_i & ~full_o & ~(ft_hit & pop_i) & ~flushing;
  assign pop_acc  = pop_i & ~cnt_zero & ~flushing;
  assign ovf_set  = push_i & full_o & ~flushing;
  assign unf_set  = pop_i & empty_o & ~flushing;

  assign kept = (keep_cnt_i < cnt) ? keep_cnt_i : cnt;

  assign almost_full_o  = (cnt >= afull_thr_i);
  assign almost_empty_o = (cnt <= aempty_thr_i);
  assign overflow_o     = err.overflow;
  assign underflow_o    = err.underflow;

  cv32e40p_fifo_wm_ptr #(
    .DEPTH     (DEPTH),
    .ADDR_DEPTH(ADDR_DEPTH)
  ) u_rptr (
    .ptr     (rptr),
    .inc_en  (pop_acc),
    .add_val ('0),
    .ptr_next(rptr_next)
  );

  cv32e40p_fifo_wm_ptr #(
    .DEPTH     (DEPTH),
    .ADDR_DEPTH(ADDR_DEPTH)
  ) u_wptr (
    .ptr     (wptr),
    .inc_en  (push_acc),
    .add_val ('0),
    .ptr_next(wptr_next)
  );

  cv32e40p_fifo_wm_ptr #(
    .DEPTH     (DEPTH),
    .ADDR_DEPTH(ADDR_DEPTH)
  ) u_keep (
    .ptr     (rptr),
    .inc_en  (1'b0),
    .add_val (kept),
    .ptr_next(wptr_keep)
  );

  // Clear first, then set, so a violation in the clearing cycle still sticks
  always_comb begin
    err_next = err;
    if (err_clr_i) begin
      err_next = '0;
    end
    err_next.overflow  = err_next.overflow | ovf_set;
    err_next.underflow = err_next.underflow | unf_set;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      err  <= '0;
    end else if (setback_i) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      err  <= '0;
    end else if (flush_i) begin
      rptr <= '0;
      wptr <= '0;
      cnt  <= '0;
      err  <= err_next;
    end else if (flush_keep_i) begin
      wptr <= wptr_keep;
      cnt  <= kept;
      err  <= err_next;
    end else begin
      rptr <= rptr_next;
      wptr <= wptr_next;
      err  <= err_next;
      if (push_acc && !pop_acc) begin
        cnt <= cnt + CNT_ONE;
      end else if (pop_acc && !push_acc) begin
        cnt <= cnt - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (setback_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (push_acc) begin
      mem[wptr] <= data_i;
    end
  end

endmodule
